systolic_mm_array: RTL and testbench
====================================

Name: systolic_mm_array

Overview:
Parametrised N x N output-stationary systolic matrix-multiply engine, the next generation of the 8x8 1-bit OR/AND array.
- Generalised in size (N), element width (W), accumulator width (ACC_W) and arithmetic mode.
- Adds internal input skewing, zero-bubble injection, a load/drain/read FSM and a valid/ready row-wise readout.
- Sits between the ui_in-style operand streams and the uo_out result path of the top-level processor.

Parameters:
N, 4, array rows = columns = number of operands per beat
W, 4, unsigned operand width in bits
ACC_W, 12, accumulator width per cell; must be >= 2*W (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
mode  in  2  0=wrap MAC, 1=saturating MAC, 2=boolean OR-AND, 3=reserved (behaves as 0); sampled on first beat only
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat
in_last  in  1  marks the final beat (k = K-1) of a job
a_in  in  N*W  column k of A; element i in bits [i*W +: W]
b_in  in  N*W  row k of B; element j in bits [j*W +: W]
out_valid  out  1  result row available
out_ready  in  1  consumer accepts row
out_data  out  N*ACC_W  row r of C; C[r][j] in bits [j*ACC_W +: ACC_W]; 0 when out_valid=0
out_row  out  clog2(N) (min 1)  index r of the presented row
busy  out  1  high in LOAD, DRAIN, READ

Behaviour:
Reset (async, rst_n=0):
- FSM=IDLE; all skew registers, cell operand registers and accumulators = 0.
- in_ready=1, out_valid=0, out_data=0, out_row=0, busy=0.
- Applies immediately in any state, including mid-job; the partial job is discarded.

FSM states: IDLE, LOAD, DRAIN, READ.
- Beat accepted = in_valid & in_ready; in_ready=1 in IDLE and LOAD only.
- IDLE, beat accepted:
  - latch mode into mode_q;
  - clear all accumulators in the same edge;
  - inject the beat;
  - go to LOAD, or to DRAIN if in_last=1 (K=1).
- LOAD, beat accepted with in_last=1: go to DRAIN.
- LOAD, in_valid=0: inject an all-zero beat (bubble); K counts accepted beats only.
- DRAIN: zero beats injected; lasts exactly 2N-1 cycles (counter), then READ.
- READ: out_valid=1, out_row=r starting at 0; r increments on out_valid & out_ready. Handshake on r=N-1 returns to IDLE. out_ready=0 holds out_data/out_row stable.
- mode changes after the first beat are ignored until the next job.

Datapath:
- Row operand a_i is delayed i cycles; column operand b_j is delayed j cycles (skew shift registers).
- Cell (i,j) registers a rightward and b downward each cycle, so the products for a given k meet in cell (i,j) i+j+1 cycles after acceptance.
- Accumulators persist after READ until the next job's first beat; readout is non-destructive.
- Per-cell update, using mode_q, with p = a*b (2W-bit unsigned, zero-extended to ACC_W):
  - mode 0: acc <= acc + p mod 2^ACC_W.
  - mode 1: acc <= min(acc + p, 2^ACC_W - 1), computed without overflow.
  - mode 2: acc <= acc | ((a!=0) & (b!=0)); result is 0/1 in bit 0.
- Zero bubbles contribute nothing in any mode.

Simultaneous and boundary cases:
- A beat presented in DRAIN/READ is not accepted (in_ready=0); it must be held by the source.
- in_last with in_valid=0 is ignored.
- There is no K limit; wrap and saturation are governed solely by mode.

Test Plan:
1. Identity product (N=4, W=4, ACC_W=12, mode 0): A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,0}; K=4 back-to-back beats. Required: rows of C equal rows of B; first out_valid exactly 4+2N-1 cycles after the first beat.
2. Wrap vs saturate: all operands 15.
   - K=16 in mode 0: every C=3600.
   - K=19 in mode 0: every C=179.
   - K=19 in mode 1: every C=4095.
3. Boolean mode 2: A col0={1,0,0,0}, B row0={0,3,0,0}, K=1 (in_last on first beat). Required: C[0][1]=1, all others 0; IDLE->DRAIN directly.
4. Bubbles and backpressure: test 1 with in_valid low on alternate cycles and out_ready low for 3 cycles per row. Required: same C; out_data/out_row stable while stalled; in_ready=0 throughout DRAIN/READ.
5. Reset mid-operation: assert rst_n=0 for 1 cycle during DRAIN of test 2. Required: out_valid=0, busy=0, in_ready=1 immediately. A following K=1 job with a=b=all 1 gives C=1 everywhere, with no residue from the aborted job.
6. Back-to-back jobs with mode changed mid-LOAD: run job1 in mode 0 and toggle mode to 1 during LOAD. Required: mode 0 results. A new beat accepted in IDLE right after the last READ handshake clears the accumulators and starts job 2 with no lost cycle.

Source files
------------

// File: rtl/systolic_mm_array_if.sv
// systolic_mm_array_if
//   Operand-stream / result-row bundle for the systolic matrix-multiply engine.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the array (drives in_ready, result row, busy)
//   mode      - arithmetic mode, sampled on the first beat of a job
//   in_*      - operand beat handshake; a_in = column k of A, b_in = row k of B
//   out_*     - row-wise readout handshake; out_row = index of presented row
//   busy      - job in progress (load, drain or read)
interface systolic_mm_array_if #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int ACC_W = 12
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]         mode;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [N*W-1:0]     a_in;
    logic [N*W-1:0]     b_in;
    logic               out_valid;
    logic               out_ready;
    logic [N*ACC_W-1:0] out_data;
    logic [RW-1:0]      out_row;
    logic               busy;

    modport master (
        output mode, in_valid, in_last, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_data, out_row, busy
    );

    modport slave (
        input  mode, in_valid, in_last, a_in, b_in, out_ready,
        output in_ready, out_valid, out_data, out_row, busy
    );
endinterface

// File: rtl/systolic_mm_array.sv
// systolic_mm_array
//   N x N output-stationary systolic matrix multiplier. Operand beats (column k
//   of A, row k of B) are skewed on entry, flow right/down through the cell
//   operand registers and are accumulated in place. After the last beat the
//   array drains for 2N-1 cycles, then C is read out one row per handshake.
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   bus        - systolic_mm_array_if.slave (operand stream, result rows, busy)
module systolic_mm_array #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int ACC_W = 12
) (
    input logic               clk,
    input logic               rst_n,
    systolic_mm_array_if.slave bus
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(2 * N);

    if (ACC_W < 2 * W) begin : g_bad_acc_w
        $error("systolic_mm_array: ACC_W must be >= 2*W");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_READ} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] row_q;
    logic [1:0]    mode_q;
    logic          in_ready_q, out_valid_q, busy_q;
    logic          accept, clr;

    assign accept = bus.in_valid & in_ready_q;
    // The first beat of a job wipes the previous result in the same edge.
    assign clr    = accept & (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            row_q       <= '0;
            mode_q      <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    // Reserved mode 3 folds onto wrap MAC here so cells see 0..2.
                    mode_q <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;
                    busy_q <= 1'b1;
                    cnt    <= '0;
                    if (bus.in_last) begin
                        state      <= S_DRAIN;
                        in_ready_q <= 1'b0;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: if (accept && bus.in_last) begin
                    state      <= S_DRAIN;
                    in_ready_q <= 1'b0;
                    cnt        <= '0;
                end
                S_DRAIN: begin
                    // Last beat reaches cell (N-1,N-1) and accumulates 2N-1 edges later.
                    if (cnt == CW'(2 * N - 2)) begin
                        state       <= S_READ;
                        out_valid_q <= 1'b1;
                        row_q       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_READ: if (bus.out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        row_q       <= '0;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [W-1:0]     a_feed [N];
    logic [W-1:0]     b_feed [N];
    logic [W-1:0]     a_edge [N];
    logic [W-1:0]     b_edge [N];
    logic [W-1:0]     a_op   [N][N];
    logic [W-1:0]     b_op   [N][N];
    logic [ACC_W-1:0] acc    [N][N];

    // Non-accepted cycles (bubbles, held beats in DRAIN/READ) inject zeros.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_feed[i] = accept ? bus.a_in[i*W +: W] : '0;
            b_feed[i] = accept ? bus.b_in[i*W +: W] : '0;
        end
    end

    // Entry skew: row operand i and column operand j are delayed i / j cycles.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign a_edge[0] = a_feed[0];
            assign b_edge[0] = b_feed[0];
        end else begin : g_delay
            logic [gi-1:0][W-1:0] a_sh, b_sh;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_sh <= '0;
                    b_sh <= '0;
                end else begin
                    a_sh[0] <= a_feed[gi];
                    b_sh[0] <= b_feed[gi];
                    for (int d = 1; d < gi; d++) begin
                        a_sh[d] <= a_sh[d-1];
                        b_sh[d] <= b_sh[d-1];
                    end
                end
            end
            assign a_edge[gi] = a_sh[gi-1];
            assign b_edge[gi] = b_sh[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [W-1:0]     a_l, b_t, a_q, b_q;
            logic [2*W-1:0]   p;
            logic [ACC_W:0]   sum;
            logic [ACC_W-1:0] acc_q, acc_nxt;

            if (gj == 0) begin : g_a_edge
                assign a_l = a_edge[gi];
            end else begin : g_a_nbr
                assign a_l = a_op[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_t = b_edge[gj];
            end else begin : g_b_nbr
                assign b_t = b_op[gi-1][gj];
            end

            assign p   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
            // One extra bit so saturation is detected without overflow.
            assign sum = {1'b0, acc_q} + {1'b0, ACC_W'(p)};

            always_comb begin
                acc_nxt = sum[ACC_W-1:0];
                case (mode_q)
                    2'd1:    acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                    2'd2:    acc_nxt = acc_q | ACC_W'((|a_q) & (|b_q));
                    default: acc_nxt = sum[ACC_W-1:0];
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_l;
                    b_q   <= b_t;
                    acc_q <= clr ? '0 : acc_nxt;
                end
            end

            assign a_op[gi][gj] = a_q;
            assign b_op[gi][gj] = b_q;
            assign acc[gi][gj]  = acc_q;
        end
    end

    // Readout is non-destructive; data is forced to zero outside READ.
    logic [N*ACC_W-1:0] odata;
    always_comb begin
        odata = '0;
        for (int j = 0; j < N; j++) begin
            odata[j*ACC_W +: ACC_W] = out_valid_q ? acc[row_q][j] : '0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = odata;
    assign bus.out_row   = row_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_systolic_mm_array.sv
// tb_systolic_mm_array
//   Randomized and directed jobs checked against a plain-arithmetic model of
//   C = sum_k A[:,k] * B[k,:] under the selected mode.
module tb_systolic_mm_array;
    localparam int N     = 4;
    localparam int W     = 4;
    localparam int ACC_W = 12;
    localparam int KMAX  = 32;
    localparam int AMAX  = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_mm_array_if #(.N(N), .W(W), .ACC_W(ACC_W)) bus ();
    systolic_mm_array #(.N(N), .W(W), .ACC_W(ACC_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ka [KMAX][N];
    int kb [KMAX][N];
    int exp_c [N][N];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_a(input int k);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(ka[k][i]);
        return v;
    endfunction

    function automatic logic [N*W-1:0] pack_b(input int k);
        logic [N*W-1:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = W'(kb[k][j]);
        return v;
    endfunction

    function automatic void model(input int md, input int kn);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int c = 0;
                for (int k = 0; k < kn; k++) begin
                    int p = ka[k][i] * kb[k][j];
                    case (md)
                        1:       c = (c + p > AMAX) ? AMAX : c + p;
                        2:       c = c | ((ka[k][i] != 0 && kb[k][j] != 0) ? 1 : 0);
                        default: c = (c + p) % (AMAX + 1);
                    endcase
                end
                exp_c[i][j] = c;
            end
    endfunction

    task automatic fill_const(input int v);
        for (int k = 0; k < KMAX; k++)
            for (int i = 0; i < N; i++) begin
                ka[k][i] = v;
                kb[k][i] = v;
            end
    endtask

    task automatic fill_identity();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                ka[k][i] = (i == k) ? 1 : 0;
                kb[k][i] = (k * N + i + 1) % 16;
            end
    endtask

    task automatic fill_rand(input int kn);
        for (int k = 0; k < kn; k++)
            for (int i = 0; i < N; i++) begin
                ka[k][i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
                kb[k][i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            end
    endtask

    // Presents K beats starting at the current negedge; mode toggles after beat 0.
    task automatic send_job(input int md, input int kn, input bit bub,
                            output int t0, output int tl);
        int k = 0;
        int n = 0;
        t0 = cyc;
        tl = cyc;
        while (k < kn && n < 200) begin
            if (bub && (n % 2 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom_range(0, 1));
                bus.a_in     = (N*W)'($urandom);
                bus.b_in     = (N*W)'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.a_in     = pack_a(k);
                bus.b_in     = pack_b(k);
                bus.in_last  = (k == kn - 1);
            end
            bus.mode = (k == 0) ? 2'(md) : 2'(md ^ 1);
            if (bus.in_valid) chk("in_ready_load", bus.in_ready, 1);
            if (bus.in_valid && bus.in_ready) begin
                if (k == 0) t0 = cyc;
                if (k == kn - 1) tl = cyc;
                k++;
            end
            n++;
            @(negedge clk);
        end
        if (k < kn) chk("load_timeout", k, kn);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Holds a non-zero beat during DRAIN; it must not be taken.
    task automatic drain_wait(input int t0, input int tl);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.a_in     = '1;
        bus.b_in     = '1;
        while (!bus.out_valid && w < 100) begin
            chk("in_ready_drain", bus.in_ready, 0);
            chk("busy_drain", bus.busy, 1);
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b0;
        chk("out_valid_seen", bus.out_valid, 1);
        chk("latency", cyc - t0, tl - t0 + 2 * N);
    endtask

    task automatic chk_row(input int r);
        chk("out_valid", bus.out_valid, 1);
        chk("out_row", bus.out_row, r);
        chk("in_ready_read", bus.in_ready, 0);
        for (int j = 0; j < N; j++)
            chk($sformatf("c%0d%0d", r, j), bus.out_data[j*ACC_W +: ACC_W], exp_c[r][j]);
    endtask

    task automatic read_rows(input int stall);
        for (int r = 0; r < N; r++) begin
            for (int s = 0; s < stall; s++) begin
                bus.out_ready = 1'b0;
                chk_row(r);
                @(negedge clk);
            end
            chk_row(r);
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_in_ready", bus.in_ready, 1);
        chk("idle_out_data", bus.out_data, 0);
    endtask

    task automatic run_job(input int md, input int kn, input bit bub, input int stall);
        int t0, tl;
        model(md, kn);
        send_job(md, kn, bub, t0, tl);
        drain_wait(t0, tl);
        read_rows(stall);
    endtask

    initial begin
        int t0, tl;
        bus.mode = 2'd0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_row", bus.out_row, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // identity product
        fill_identity();
        run_job(0, 4, 0, 0);

        // wrap vs saturate with all-15 operands
        fill_const(15);
        run_job(0, 16, 0, 0);
        run_job(0, 19, 0, 0);
        run_job(1, 19, 0, 0);

        // boolean single-beat job
        fill_const(0);
        ka[0][0] = 1;
        kb[0][1] = 3;
        run_job(2, 1, 0, 0);

        // bubbles and backpressure
        fill_identity();
        run_job(0, 4, 1, 3);

        // reset during DRAIN, then a clean K=1 job
        fill_const(15);
        send_job(0, 19, 0, t0, tl);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_const(1);
        run_job(0, 1, 0, 0);

        // back-to-back jobs, mode toggled during load
        fill_rand(6);
        run_job(0, 6, 0, 0);
        fill_rand(5);
        run_job(1, 5, 0, 1);

        // randomized jobs
        repeat (8) begin
            int md = $urandom_range(0, 3);
            int kn = $urandom_range(1, 20);
            fill_rand(kn);
            run_job(md, kn, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
